shift_width_fifo: RTL and testbench
===================================

# shift_width_fifo

Parametrised down-converting FIFO with ready/valid handshakes on both sides. It accepts wide words (e.g. 64-bit packed pixel groups) and emits them as a stream of narrow lanes (e.g. 8-bit pixels) into the shift/convolution datapath. It is the successor to the fixed enable/flag width FIFO and adds:
- backpressure-safe handshakes;
- a registered first-word-fall-through output;
- non-power-of-two depth;
- fill level and almost-full reporting;
- synchronous flush.

## Interface
- `InWidth`, 64: input word width; must be an integer multiple of `OutWidth`.
- `OutWidth`, 8: output lane width.
- `Depth`, 16: storage capacity in input words; any value ≥ 2.
- `AlmostFull`, 12: level threshold for `almost_full_o`; range 1..`Depth`.
- Derived: `Ratio` = `InWidth`/`OutWidth`; `LvlW` = $clog2(`Depth`+1).
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `flush_i`  in  1  synchronous clear of all contents.
- `s_valid_i`  in  1  input word valid.
- `s_ready_o`  out  1  FIFO can accept a word.
- `s_data_i`  in  `InWidth`  input word.
- `m_valid_o`  out  1  output lane valid.
- `m_ready_i`  in  1  consumer accepts lane.
- `m_data_o`  out  `OutWidth`  output lane.
- `m_last_o`  out  1  lane is the final lane of its input word.
- `level_o`  out  `LvlW`  stored words not yet fully transferred to the output register.
- `almost_full_o`  out  1  `level_o` ≥ `AlmostFull`.

## Operation
- Reset values: `m_valid_o`=0, `m_data_o`=0, `m_last_o`=0, `level_o`=0, `almost_full_o`=0, `s_ready_o`=1; write pointer, read pointer and lane index are 0.
- Write: fires when `s_valid_i` && `s_ready_o`.
  - The word is stored at the write pointer.
  - The write pointer increments and wraps explicitly from `Depth`-1 to 0.
- `s_ready_o` = (`level_o` != `Depth`). It depends only on registered state, never on `m_ready_i`.
  - When full, no write occurs even if a word drains in the same cycle.
- Output register load: occurs when (!`m_valid_o` || `m_ready_i`) && `level_o` != 0.
  - `m_data_o` takes lane `lane` of the word at the read pointer.
  - `m_valid_o` is set to 1.
  - `m_last_o` = (`lane` == `Ratio`-1).
  - Lane selection: lane k is bits [k*`OutWidth` +: `OutWidth`] (LSB-first) unless the `Configuration` macro is defined.
- On the last lane of a word:
  - `lane` returns to 0;
  - the read pointer increments and wraps;
  - the level decrements.
  - Otherwise `lane` increments.
- Output drain: `m_valid_o` && `m_ready_i` with `level_o`=0 clears `m_valid_o`. `m_data_o` and `m_last_o` hold their values.
- While `m_valid_o` && !`m_ready_i`, `m_data_o` and `m_last_o` stay stable.
- Level update: +1 on write, −1 on last-lane load, unchanged when both occur in the same cycle.
- Flush: takes priority over write, load and drain in its cycle. Next-edge values:
  - pointers and `lane` = 0;
  - `level_o` = 0;
  - `m_valid_o` = 0, `m_last_o` = 0.
  - Storage contents are not cleared.
- `Ratio` = 1: the lane index is constant 0 and `m_last_o` is always 1 when valid.

## Timing
- Write-to-output latency: a word written at edge N into an empty FIFO gives `m_valid_o`=1 after edge N+1, presenting lane 0.
- Throughput: one lane per cycle with `m_ready_i` held high; one input word per cycle until full.
- Sustained rate at the input is 1/`Ratio` words per cycle.
- `level_o`, `almost_full_o` and `s_ready_o` are registered-state functions, updated the edge after the causing event.
- Reset asserted mid-transfer: all state returns to reset values immediately (asynchronous). The partially emitted word is discarded.

## Configuration
- `SHIFT_FIFO_MSB_FIRST_EN`: lane order.
  - Defined: lane k is bits [(`Ratio`-1-k)*`OutWidth` +: `OutWidth`], so the MSB lane is emitted first.
  - Undefined: LSB-first as described in `Operation`.
  - Handshake, latency and `m_last_o` timing are identical in both builds.

## Structure
- Shared package `shift_pkg`:
  - `ratio_f` and `lvl_width_f` constant functions;
  - a typedef for the lane index.
- Sub-module `shift_fifo_ptr`: a wrap-at-`Depth` pointer counter with increment and clear inputs. It is instantiated twice, for the write and read pointers.
- Elaboration-time assertions:
  - `InWidth` % `OutWidth` == 0;
  - `Depth` ≥ 2;
  - 1 ≤ `AlmostFull` ≤ `Depth`.

## Test plan
- Basic unpack:
  - Stimulus: write 64'h0807060504030201 into an empty FIFO with `m_ready_i`=1.
  - Response: `m_valid_o` rises one cycle after the write; lanes 01..08 on consecutive cycles; `m_last_o`=1 only with 08.
  - MSB-first build: lanes 08..01.
- Fill and wrap:
  - Stimulus: `Depth`=5, `m_ready_i`=0, write 5 words.
  - Response: `s_ready_o`=0 and `level_o`=5; `almost_full_o` rises when `level_o` reaches `AlmostFull`.
  - Then drain all lanes, write 3 more words and drain them: data order is preserved across the pointer wrap.
- Backpressure:
  - Stimulus: toggle `m_ready_i` pseudo-randomly while streaming 20 words.
  - Response: no lane is lost or duplicated; `m_data_o` is stable while stalled.
- Simultaneous full write and drain:
  - Stimulus: at `level_o`=`Depth`, the last lane is consumed while `s_valid_i`=1.
  - Response: the write is refused that cycle and accepted the next cycle; `level_o` goes `Depth`-1, then `Depth`.
- Flush mid-word:
  - Stimulus: assert `flush_i` after 3 of 8 lanes have been emitted.
  - Response: the next cycle shows `m_valid_o`=0 and `level_o`=0; a following write emits from lane 0.
- Async reset mid-stream:
  - Stimulus: pulse `rst_i` between clock edges.
  - Response: all outputs return to reset values immediately; `s_ready_o`=1.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared types and constant functions for the shift/convolution width-conversion blocks.
// Lane index is sized for up to 256 lanes per input word.
package shift_pkg;

  localparam int unsigned LaneIdxW = 8;

  typedef logic [LaneIdxW-1:0] lane_idx_t;

  function automatic int unsigned ratio_f(input int unsigned in_w, input int unsigned out_w);
    return in_w / out_w;
  endfunction

  function automatic int unsigned lvl_width_f(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/shift_fifo_ptr.sv
// Wrap-at-Depth pointer counter with synchronous clear (priority) and increment.
module shift_fifo_ptr #(
  parameter int unsigned Depth = 16,
  parameter int unsigned PtrW  = $clog2(Depth)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clr_i,
  input  logic            inc_i,
  output logic [PtrW-1:0] ptr_o
);

  logic [PtrW-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (inc_i) begin
      // Explicit wrap so non-power-of-two depths work.
      ptr_d = (ptr_q == PtrW'(Depth - 1)) ? '0 : ptr_q + PtrW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/shift_width_fifo.sv
// Down-converting FIFO: stores wide words, emits them as narrow lanes through a registered
// first-word-fall-through output. Define SHIFT_FIFO_MSB_FIRST_EN to emit the MSB lane first.
module shift_width_fifo
  import shift_pkg::*;
#(
  parameter int unsigned InWidth    = 64,
  parameter int unsigned OutWidth   = 8,
  parameter int unsigned Depth      = 16,
  parameter int unsigned AlmostFull = 12,
  parameter int unsigned Ratio      = ratio_f(InWidth, OutWidth),
  parameter int unsigned LvlW       = lvl_width_f(Depth)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  logic                s_valid_i,
  output logic                s_ready_o,
  input  logic [InWidth-1:0]  s_data_i,
  output logic                m_valid_o,
  input  logic                m_ready_i,
  output logic [OutWidth-1:0] m_data_o,
  output logic                m_last_o,
  output logic [LvlW-1:0]     level_o,
  output logic                almost_full_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned SelW = (InWidth > 1) ? $clog2(InWidth) : 1;

  if (InWidth % OutWidth != 0) begin : g_chk_ratio
    $error("InWidth must be an integer multiple of OutWidth");
  end
  if (Depth < 2) begin : g_chk_depth
    $error("Depth must be at least 2");
  end
  if (AlmostFull < 1 || AlmostFull > Depth) begin : g_chk_af
    $error("AlmostFull must lie in 1..Depth");
  end
  if (Ratio > (1 << LaneIdxW)) begin : g_chk_lanes
    $error("Ratio exceeds lane index range");
  end

  logic [InWidth-1:0]  mem_q [Depth];
  logic [PtrW-1:0]     wr_ptr, rd_ptr;
  logic [LvlW-1:0]     level_q, level_d;
  lane_idx_t           lane_q, lane_d, lane_sel;
  logic                m_valid_q, m_valid_d;
  logic                m_last_q, m_last_d;
  logic [OutWidth-1:0] m_data_q, m_data_d;
  logic [InWidth-1:0]  rd_word;
  logic [SelW-1:0]     sel_base;
  logic                wr_en, load, last_lane, rd_inc;

  // Handshakes: a transfer happens on the edge where valid && ready are both high.
  // s_ready_o and m_valid_o come only from registered state, so neither side's ready
  // combinationally depends on the other side; m_data_o/m_last_o hold while stalled.
  assign s_ready_o     = (level_q != LvlW'(Depth));
  assign wr_en         = s_valid_i && s_ready_o && !flush_i;
  assign load          = (!m_valid_q || m_ready_i) && (level_q != '0) && !flush_i;
  assign last_lane     = (lane_q == lane_idx_t'(Ratio - 1));
  assign rd_inc        = load && last_lane;
  assign rd_word       = mem_q[rd_ptr];

`ifdef SHIFT_FIFO_MSB_FIRST_EN
  assign lane_sel = lane_idx_t'(Ratio - 1) - lane_q;
`else
  assign lane_sel = lane_q;
`endif
  assign sel_base = SelW'(32'(lane_sel) * OutWidth);

  shift_fifo_ptr #(.Depth(Depth), .PtrW(PtrW)) u_wr_ptr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (flush_i),
    .inc_i (wr_en),
    .ptr_o (wr_ptr)
  );

  shift_fifo_ptr #(.Depth(Depth), .PtrW(PtrW)) u_rd_ptr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (flush_i),
    .inc_i (rd_inc),
    .ptr_o (rd_ptr)
  );

  // Storage is deliberately left uninitialised; flush and reset only clear bookkeeping.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr] <= s_data_i;
  end

  always_comb begin
    level_d   = level_q;
    lane_d    = lane_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    m_data_d  = m_data_q;
    if (flush_i) begin
      level_d   = '0;
      lane_d    = '0;
      m_valid_d = 1'b0;
      m_last_d  = 1'b0;
    end else begin
      case ({wr_en, rd_inc})
        2'b10:   level_d = level_q + LvlW'(1);
        2'b01:   level_d = level_q - LvlW'(1);
        default: level_d = level_q;
      endcase
      if (load) begin
        m_data_d  = rd_word[sel_base +: OutWidth];
        m_valid_d = 1'b1;
        m_last_d  = last_lane;
        lane_d    = last_lane ? '0 : lane_q + lane_idx_t'(1);
      end else if (m_valid_q && m_ready_i) begin
        m_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      level_q   <= '0;
      lane_q    <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_data_q  <= '0;
    end else begin
      level_q   <= level_d;
      lane_q    <= lane_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      m_data_q  <= m_data_d;
    end
  end

  assign m_valid_o     = m_valid_q;
  assign m_data_o      = m_data_q;
  assign m_last_o      = m_last_q;
  assign level_o       = level_q;
  assign almost_full_o = (level_q >= LvlW'(AlmostFull));

endmodule

// File: tb/tb_shift_width_fifo.sv
// Bench for shift_width_fifo (Depth=5, AlmostFull=3): lane-order scoreboard built from the
// written words, directed boundary scenarios and a randomized backpressure stream.
module tb_shift_width_fifo;

  localparam int unsigned InW        = 64;
  localparam int unsigned OutW       = 8;
  localparam int unsigned Depth      = 5;
  localparam int unsigned AlmostFull = 3;
  localparam int unsigned Ratio      = InW / OutW;
  localparam int unsigned LvlW       = $clog2(Depth + 1);

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b1;
  logic            flush_i = 1'b0;
  logic            s_valid_i = 1'b0;
  logic            s_ready_o;
  logic [InW-1:0]  s_data_i = '0;
  logic            m_valid_o;
  logic            m_ready_i = 1'b0;
  logic [OutW-1:0] m_data_o;
  logic            m_last_o;
  logic [LvlW-1:0] level_o;
  logic            almost_full_o;

  logic [OutW-1:0] exp_q[$];
  logic            exp_last_q[$];
  int              n_checks = 0;
  int              n_pass = 0;

  // clock / reset
  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  shift_width_fifo #(
    .InWidth(InW), .OutWidth(OutW), .Depth(Depth), .AlmostFull(AlmostFull)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .flush_i       (flush_i),
    .s_valid_i     (s_valid_i),
    .s_ready_o     (s_ready_o),
    .s_data_i      (s_data_i),
    .m_valid_o     (m_valid_o),
    .m_ready_i     (m_ready_i),
    .m_data_o      (m_data_o),
    .m_last_o      (m_last_o),
    .level_o       (level_o),
    .almost_full_o (almost_full_o)
  );

  // driver helpers
  task automatic tick;
    @(negedge clk_i);
  endtask

  // Reference model: a word expands into Ratio lanes in emission order.
  task automatic push_word(input logic [InW-1:0] w);
    logic [InW-1:0] t;
    for (int k = 0; k < int'(Ratio); k++) begin
`ifdef SHIFT_FIFO_MSB_FIRST_EN
      t = w >> ((int'(Ratio) - 1 - k) * int'(OutW));
`else
      t = w >> (k * int'(OutW));
`endif
      exp_q.push_back(t[OutW-1:0]);
      exp_last_q.push_back(k == int'(Ratio) - 1);
    end
  endtask

  function automatic logic [InW-1:0] rand_word();
    return {$urandom(), $urandom()};
  endfunction

  task automatic drain_all(input string tag);
    int guard = 0;
    s_valid_i = 1'b0;
    m_ready_i = 1'b1;
    while ((exp_q.size() != 0 || m_valid_o) && guard < 300) begin
      if (m_valid_o) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL %s_extra_lane: got lane %h, expected no more lanes", tag, m_data_o);
        end else begin
          n_checks++;
          if (m_data_o !== exp_q[0])
            $display("FAIL %s_data: got %h want %h", tag, m_data_o, exp_q[0]);
          else n_pass++;
          n_checks++;
          if (m_last_o !== exp_last_q[0])
            $display("FAIL %s_last: got %b want %b", tag, m_last_o, exp_last_q[0]);
          else n_pass++;
          void'(exp_q.pop_front());
          void'(exp_last_q.pop_front());
        end
      end
      tick;
      guard++;
    end
    n_checks++;
    if (guard >= 300) $display("FAIL %s_timeout: %0d lanes outstanding, want 0", tag, exp_q.size());
    else n_pass++;
    n_checks++;
    if (level_o !== '0) $display("FAIL %s_level_end: got %0d want 0", tag, level_o);
    else n_pass++;
  endtask

  task automatic test_reset;
    tick;
    tick;
    n_checks++; if (m_valid_o !== 1'b0) $display("FAIL reset_m_valid: got %b want 0", m_valid_o); else n_pass++;
    n_checks++; if (m_data_o !== '0) $display("FAIL reset_m_data: got %h want 00", m_data_o); else n_pass++;
    n_checks++; if (m_last_o !== 1'b0) $display("FAIL reset_m_last: got %b want 0", m_last_o); else n_pass++;
    n_checks++; if (level_o !== '0) $display("FAIL reset_level: got %0d want 0", level_o); else n_pass++;
    n_checks++; if (almost_full_o !== 1'b0) $display("FAIL reset_af: got %b want 0", almost_full_o); else n_pass++;
    n_checks++; if (s_ready_o !== 1'b1) $display("FAIL reset_s_ready: got %b want 1", s_ready_o); else n_pass++;
    rst_i = 1'b0;
    tick;
    n_checks++; if (m_valid_o !== 1'b0) $display("FAIL idle_m_valid: got %b want 0", m_valid_o); else n_pass++;
    n_checks++; if (s_ready_o !== 1'b1) $display("FAIL idle_s_ready: got %b want 1", s_ready_o); else n_pass++;
  endtask

  task automatic test_basic;
    logic [InW-1:0] w = 64'h0807060504030201;
    m_ready_i = 1'b1;
    s_valid_i = 1'b1;
    s_data_i  = w;
    push_word(w);
    tick;
    s_valid_i = 1'b0;
    n_checks++; if (m_valid_o !== 1'b0) $display("FAIL basic_latency: m_valid got %b want 0", m_valid_o); else n_pass++;
    n_checks++; if (level_o !== LvlW'(1)) $display("FAIL basic_level: got %0d want 1", level_o); else n_pass++;
    for (int k = 0; k < int'(Ratio); k++) begin
      tick;
      n_checks++; if (m_valid_o !== 1'b1) $display("FAIL basic_valid_%0d: got %b want 1", k, m_valid_o); else n_pass++;
      n_checks++; if (m_data_o !== exp_q[0]) $display("FAIL basic_data_%0d: got %h want %h", k, m_data_o, exp_q[0]); else n_pass++;
      n_checks++; if (m_last_o !== exp_last_q[0]) $display("FAIL basic_last_%0d: got %b want %b", k, m_last_o, exp_last_q[0]); else n_pass++;
      void'(exp_q.pop_front());
      void'(exp_last_q.pop_front());
    end
    tick;
    n_checks++; if (m_valid_o !== 1'b0) $display("FAIL basic_drained: m_valid got %b want 0", m_valid_o); else n_pass++;
    n_checks++; if (level_o !== '0) $display("FAIL basic_level_end: got %0d want 0", level_o); else n_pass++;
  endtask

  task automatic test_fill_wrap;
    m_ready_i = 1'b0;
    for (int i = 0; i < int'(Depth); i++) begin
      n_checks++; if (s_ready_o !== 1'b1) $display("FAIL fill_s_ready_%0d: got %b want 1", i, s_ready_o); else n_pass++;
      s_valid_i = 1'b1;
      s_data_i  = rand_word();
      push_word(s_data_i);
      tick;
      n_checks++; if (level_o !== LvlW'(i + 1)) $display("FAIL fill_level_%0d: got %0d want %0d", i, level_o, i + 1); else n_pass++;
      n_checks++;
      if (almost_full_o !== ((i + 1) >= int'(AlmostFull)))
        $display("FAIL fill_af_%0d: got %b want %b", i, almost_full_o, ((i + 1) >= int'(AlmostFull)));
      else n_pass++;
    end
    s_valid_i = 1'b0;
    n_checks++; if (s_ready_o !== 1'b0) $display("FAIL full_s_ready: got %b want 0", s_ready_o); else n_pass++;
    drain_all("fill");
    m_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_valid_i = 1'b1;
      s_data_i  = rand_word();
      push_word(s_data_i);
      tick;
    end
    s_valid_i = 1'b0;
    n_checks++; if (level_o !== LvlW'(3)) $display("FAIL wrap_level: got %0d want 3", level_o); else n_pass++;
    drain_all("wrap");
  endtask

  task automatic test_backpressure;
    int              sent = 0;
    int              guard = 0;
    logic            stall = 1'b0;
    logic [OutW-1:0] held_d = '0;
    logic            held_l = 1'b0;
    while ((sent < 20 || exp_q.size() != 0 || m_valid_o) && guard < 3000) begin
      if (stall) begin
        n_checks++; if (m_valid_o !== 1'b1) $display("FAIL bp_stall_valid: got %b want 1", m_valid_o); else n_pass++;
        n_checks++; if (m_data_o !== held_d) $display("FAIL bp_stall_data: got %h want %h", m_data_o, held_d); else n_pass++;
        n_checks++; if (m_last_o !== held_l) $display("FAIL bp_stall_last: got %b want %b", m_last_o, held_l); else n_pass++;
      end
      s_valid_i = (sent < 20) && ($urandom_range(0, 3) != 0);
      s_data_i  = rand_word();
      m_ready_i = $urandom_range(0, 1) == 1;
      if (m_valid_o && m_ready_i) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL bp_extra_lane: got lane %h, expected no more lanes", m_data_o);
        end else begin
          n_checks++; if (m_data_o !== exp_q[0]) $display("FAIL bp_data: got %h want %h", m_data_o, exp_q[0]); else n_pass++;
          n_checks++; if (m_last_o !== exp_last_q[0]) $display("FAIL bp_last: got %b want %b", m_last_o, exp_last_q[0]); else n_pass++;
          void'(exp_q.pop_front());
          void'(exp_last_q.pop_front());
        end
      end
      if (s_valid_i && s_ready_o) begin
        push_word(s_data_i);
        sent++;
      end
      stall  = m_valid_o && !m_ready_i;
      held_d = m_data_o;
      held_l = m_last_o;
      tick;
      guard++;
    end
    s_valid_i = 1'b0;
    n_checks++; if (guard >= 3000) $display("FAIL bp_timeout: sent %0d, %0d lanes outstanding, want 20/0", sent, exp_q.size()); else n_pass++;
    n_checks++; if (level_o !== '0) $display("FAIL bp_level_end: got %0d want 0", level_o); else n_pass++;
  endtask

  task automatic test_full_write_drain;
    int exp_lvl;
    m_ready_i = 1'b0;
    for (int i = 0; i < int'(Depth); i++) begin
      s_valid_i = 1'b1;
      s_data_i  = rand_word();
      push_word(s_data_i);
      tick;
    end
    n_checks++; if (level_o !== LvlW'(Depth)) $display("FAIL fwd_level_full: got %0d want %0d", level_o, Depth); else n_pass++;
    n_checks++; if (s_ready_o !== 1'b0) $display("FAIL fwd_s_ready_full: got %b want 0", s_ready_o); else n_pass++;
    // The extra word is held on the input until the FIFO makes room.
    s_data_i  = rand_word();
    push_word(s_data_i);
    s_valid_i = 1'b1;
    m_ready_i = 1'b1;
    for (int e = 1; e <= int'(Ratio); e++) begin
      n_checks++; if (m_data_o !== exp_q[0]) $display("FAIL fwd_data_%0d: got %h want %h", e, m_data_o, exp_q[0]); else n_pass++;
      void'(exp_q.pop_front());
      void'(exp_last_q.pop_front());
      tick;
      exp_lvl = (e == int'(Ratio) - 1) ? int'(Depth) - 1 : int'(Depth);
      n_checks++; if (level_o !== LvlW'(exp_lvl)) $display("FAIL fwd_level_%0d: got %0d want %0d", e, level_o, exp_lvl); else n_pass++;
      n_checks++;
      if (s_ready_o !== (e == int'(Ratio) - 1))
        $display("FAIL fwd_s_ready_%0d: got %b want %b", e, s_ready_o, (e == int'(Ratio) - 1));
      else n_pass++;
    end
    s_valid_i = 1'b0;
    drain_all("fwd");
  endtask

  task automatic test_flush;
    m_ready_i = 1'b1;
    s_valid_i = 1'b1;
    s_data_i  = rand_word();
    push_word(s_data_i);
    tick;
    s_valid_i = 1'b0;
    tick;
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (m_data_o !== exp_q[0]) $display("FAIL flush_pre_data_%0d: got %h want %h", k, m_data_o, exp_q[0]); else n_pass++;
      void'(exp_q.pop_front());
      void'(exp_last_q.pop_front());
      tick;
    end
    flush_i = 1'b1;
    tick;
    flush_i = 1'b0;
    exp_q.delete();
    exp_last_q.delete();
    n_checks++; if (m_valid_o !== 1'b0) $display("FAIL flush_m_valid: got %b want 0", m_valid_o); else n_pass++;
    n_checks++; if (m_last_o !== 1'b0) $display("FAIL flush_m_last: got %b want 0", m_last_o); else n_pass++;
    n_checks++; if (level_o !== '0) $display("FAIL flush_level: got %0d want 0", level_o); else n_pass++;
    n_checks++; if (s_ready_o !== 1'b1) $display("FAIL flush_s_ready: got %b want 1", s_ready_o); else n_pass++;
    s_valid_i = 1'b1;
    s_data_i  = rand_word();
    push_word(s_data_i);
    tick;
    drain_all("post_flush");
  endtask

  task automatic test_async_reset;
    m_ready_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      s_valid_i = 1'b1;
      s_data_i  = rand_word();
      tick;
    end
    s_valid_i = 1'b0;
    tick;
    tick;
    #2;
    rst_i = 1'b1;
    #1;
    n_checks++; if (m_valid_o !== 1'b0) $display("FAIL arst_m_valid: got %b want 0", m_valid_o); else n_pass++;
    n_checks++; if (m_data_o !== '0) $display("FAIL arst_m_data: got %h want 00", m_data_o); else n_pass++;
    n_checks++; if (m_last_o !== 1'b0) $display("FAIL arst_m_last: got %b want 0", m_last_o); else n_pass++;
    n_checks++; if (level_o !== '0) $display("FAIL arst_level: got %0d want 0", level_o); else n_pass++;
    n_checks++; if (almost_full_o !== 1'b0) $display("FAIL arst_af: got %b want 0", almost_full_o); else n_pass++;
    n_checks++; if (s_ready_o !== 1'b1) $display("FAIL arst_s_ready: got %b want 1", s_ready_o); else n_pass++;
    #1;
    rst_i = 1'b0;
    tick;
    exp_q.delete();
    exp_last_q.delete();
    s_valid_i = 1'b1;
    s_data_i  = rand_word();
    push_word(s_data_i);
    tick;
    drain_all("post_reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill_wrap();
    test_backpressure();
    test_full_write_drain();
    test_flush();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
